vga_pixel_sink: RTL and testbench
=================================

// Module: vga_pixel_sink
// PURPOSE
//  Receiving end of the pixel-write interface (x, y, color, write) driven by the drawing
//  blocks: game renderer, win/lose screens. Accepts one pixel per cycle with no
//  backpressure, clips off-screen writes and converts (x,y) to a linear framebuffer address.
//  Buffers pixels in a FIFO and drains them to the framebuffer write port whenever the
//  scan-out arbiter grants access. Sits between the master-FSM source mux and the framebuffer.
// PARAMETERS
//  XSCREEN     640  visible width; x >= XSCREEN is clipped
//  YSCREEN     480  visible height; y >= YSCREEN is clipped
//  FIFO_DEPTH  16   pixel FIFO entries (power of 2)
//  FIFO_AW     4    log2(FIFO_DEPTH)
// PORTS
//  Clock           in   1   system clock
//  Resetn          in   1   synchronous, active-low reset
//  in_x            in   10  pixel x
//  in_y            in   9   pixel y
//  in_color        in   9   pixel color, RRR_GGG_BBB
//  in_write        in   1   pixel valid this cycle; no ready; source never stalls
//  fb_grant        in   1   framebuffer port available this cycle
//  fb_addr         out  19  linear address = y*XSCREEN + x
//  fb_data         out  9   pixel color
//  fb_we           out  1   framebuffer write strobe, one cycle per pixel
//  clear_overflow  in   1   clears sticky overflow
//  overflow        out  1   sticky: a pixel was dropped on a full FIFO
//  clipped         out  1   one-cycle pulse: an off-screen pixel was discarded
//  busy            out  1   any pixel in flight (S1, S2, FIFO or fb_we)
// BEHAVIOUR
//  Reset: all outputs 0, FIFO emptied, pipeline valids cleared. Reset mid-operation
//   discards every buffered pixel; no fb_we in the cycle after reset.
//  S1: if in_write, register x/y/color, set v1. Otherwise v1 = 0.
//  S2: from S1, if v1 and (x >= XSCREEN or y >= YSCREEN), clear v2 and pulse clipped.
//   Otherwise compute addr = (y<<9) + (y<<7) + x as 19-bit unsigned and set v2 = v1.
//   Use shift-add; no multiplier.
//  Push: if v2, write {addr, color} to the FIFO. If the FIFO is full and no pop occurs
//   this cycle, drop the pixel and set overflow.
//   A push to a full FIFO with a simultaneous pop is accepted.
//  Pop: if FIFO not empty and fb_grant, pop the head. Next cycle fb_we = 1 with
//   fb_addr/fb_data = popped entry. Otherwise fb_we = 0 and fb_addr/fb_data hold.
//  No bypass: push into an empty FIFO becomes poppable one cycle later.
//   Min latency in_write -> fb_we = 4 cycles (FIFO empty, grant high).
//  Sustained throughput: 1 pixel/cycle while fb_grant stays high.
//  Order is preserved; no pixel is written twice.
//  overflow: set has priority over clear_overflow in the same cycle.
//  busy = v1 | v2 | !empty | fb_we.
//  Pointers are FIFO_AW+1 bits; full/empty derive from the MSB compare; wrap is natural.
// STRUCTURE
//  Shared package/include: XSCREEN, YSCREEN, color width 9, FB address width 19,
//   color constants.
//  Sub-module pixel_fifo: synchronous FIFO, width 28 ({addr, color}), depth FIFO_DEPTH,
//   ports push/pop/din/dout/full/empty. Top holds S1/S2, clip, address, flags, fb regs.
// TESTING
//  T1: grant=1, single write (x=10, y=2, c=9'h038) -> fb_we 4 cycles later,
//      fb_addr=1290, fb_data=9'h038.
//  T2: writes at (639,479) and (640,0) -> first gives addr 307199; second pulses clipped,
//      no fb_we.
//  T3: grant=0, 20 back-to-back writes -> 16 buffered, overflow=1. Then grant=1:
//      exactly 16 fb_we in order, busy drops.
//  T4: FIFO full, push and pop in the same cycle -> no drop, overflow stays 0.
//  T5: grant toggled every cycle, 50-write burst (≤ 16 backlog) -> all 50 arrive in order.
//  T6: Resetn low with 8 pixels buffered -> fb_we=0 and busy=0 after reset; no stale
//      writes later.

Source files
------------

// File: rtl/vga_pixel_sink_pkg.sv
// Shared screen geometry, framebuffer word layout and colour constants for the
// pixel-write path between the drawing blocks and the framebuffer.
package vga_pixel_sink_pkg;

   localparam int unsigned X_W     = 10;
   localparam int unsigned Y_W     = 9;
   localparam int unsigned COLOR_W = 9;
   localparam int unsigned ADDR_W  = 19;
   localparam int unsigned ENTRY_W = ADDR_W + COLOR_W;

   localparam logic [X_W-1:0] XSCREEN = 10'd640;
   localparam logic [Y_W-1:0] YSCREEN = 9'd480;

   typedef logic [COLOR_W-1:0] color_t;
   typedef logic [ADDR_W-1:0]  fb_addr_t;

   typedef struct packed {
      fb_addr_t addr;
      color_t   color;
   } fb_entry_t;

   // RRR_GGG_BBB
   localparam color_t COLOR_BLACK = 9'h000;
   localparam color_t COLOR_WHITE = 9'h1FF;
   localparam color_t COLOR_RED   = 9'h1C0;
   localparam color_t COLOR_GREEN = 9'h038;
   localparam color_t COLOR_BLUE  = 9'h007;

   // y*640 + x as two shifts and adds; only valid for on-screen coordinates
   function automatic fb_addr_t xy_to_addr(input logic [X_W-1:0] x,
                                           input logic [Y_W-1:0] y);
      fb_addr_t yy;
      yy = fb_addr_t'(y);
      return (yy << 9) + (yy << 7) + fb_addr_t'(x);
   endfunction

endpackage

// File: rtl/vga_pixel_sink_fifo.sv
// Synchronous pixel FIFO with (AW+1)-bit pointers; a push while full is taken
// only when a pop happens in the same cycle. No read-to-write bypass.
module pixel_fifo #(
   parameter int unsigned W     = 28,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic         Clock,
   input  logic         Resetn,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   logic         pop_ok, push_ok;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign dout  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      pop_ok  = pop && !empty;
      push_ok = push && (!full || pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q[AW-1:0]] = din;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge Clock) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/vga_pixel_sink.sv
// Pixel-write sink: registers incoming pixels, clips off-screen writes, forms the
// linear framebuffer address, buffers in a FIFO and drains on fb_grant.
module vga_pixel_sink
   import vga_pixel_sink_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned FIFO_AW    = 4
) (
   input  logic               Clock,
   input  logic               Resetn,
   input  logic [X_W-1:0]     in_x,
   input  logic [Y_W-1:0]     in_y,
   input  logic [COLOR_W-1:0] in_color,
   input  logic               in_write,
   input  logic               fb_grant,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic [COLOR_W-1:0] fb_data,
   output logic               fb_we,
   input  logic               clear_overflow,
   output logic               overflow,
   output logic               clipped,
   output logic               busy
);

   logic [X_W-1:0] x1_q, x1_d;
   logic [Y_W-1:0] y1_q, y1_d;
   color_t         c1_q, c1_d;
   logic           v1_q, v1_d;
   fb_entry_t      e2_q, e2_d;
   logic           v2_q, v2_d;
   logic           clipped_q, clipped_d;
   logic           overflow_q, overflow_d;
   logic           fb_we_q, fb_we_d;
   fb_addr_t       fb_addr_q, fb_addr_d;
   color_t         fb_data_q, fb_data_d;

   logic               off_screen;
   logic               fifo_pop;
   logic               fifo_full, fifo_empty;
   logic [ENTRY_W-1:0] fifo_dout;
   fb_entry_t          head;

   pixel_fifo #(
      .W     (ENTRY_W),
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW)
   ) u_fifo (
      .Clock  (Clock),
      .Resetn (Resetn),
      .push   (v2_q),
      .pop    (fifo_pop),
      .din    (e2_q),
      .dout   (fifo_dout),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign head     = fb_entry_t'(fifo_dout);
   assign fifo_pop = fb_grant && !fifo_empty;

   always_comb begin
      // S1 payload is captured every cycle; only v1 qualifies it
      x1_d = in_x;
      y1_d = in_y;
      c1_d = in_color;
      v1_d = in_write;

      off_screen = (x1_q >= XSCREEN) || (y1_q >= YSCREEN);
      clipped_d  = v1_q && off_screen;
      v2_d       = v1_q && !off_screen;
      e2_d.addr  = xy_to_addr(x1_q, y1_q);
      e2_d.color = c1_q;

      overflow_d = overflow_q;
      if (v2_q && fifo_full && !fifo_pop) begin
         overflow_d = 1'b1;
      end else if (clear_overflow) begin
         overflow_d = 1'b0;
      end

      fb_we_d   = fifo_pop;
      fb_addr_d = fb_addr_q;
      fb_data_d = fb_data_q;
      if (fifo_pop) begin
         fb_addr_d = head.addr;
         fb_data_d = head.color;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         x1_q       <= '0;
         y1_q       <= '0;
         c1_q       <= '0;
         v1_q       <= 1'b0;
         e2_q       <= '0;
         v2_q       <= 1'b0;
         clipped_q  <= 1'b0;
         overflow_q <= 1'b0;
         fb_we_q    <= 1'b0;
         fb_addr_q  <= '0;
         fb_data_q  <= '0;
      end else begin
         x1_q       <= x1_d;
         y1_q       <= y1_d;
         c1_q       <= c1_d;
         v1_q       <= v1_d;
         e2_q       <= e2_d;
         v2_q       <= v2_d;
         clipped_q  <= clipped_d;
         overflow_q <= overflow_d;
         fb_we_q    <= fb_we_d;
         fb_addr_q  <= fb_addr_d;
         fb_data_q  <= fb_data_d;
      end
   end

   assign fb_we    = fb_we_q;
   assign fb_addr  = fb_addr_q;
   assign fb_data  = fb_data_q;
   assign overflow = overflow_q;
   assign clipped  = clipped_q;
   assign busy     = v1_q | v2_q | !fifo_empty | fb_we_q;

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Scoreboard bench for vga_pixel_sink: expected framebuffer writes are queued
// at stimulus time from y*640+x and popped by a monitor on every fb_we.
module tb_vga_pixel_sink;

   logic        Clock = 1'b0;
   logic        Resetn = 1'b0;
   logic [9:0]  in_x = '0;
   logic [8:0]  in_y = '0;
   logic [8:0]  in_color = '0;
   logic        in_write = 1'b0;
   logic        fb_grant = 1'b0;
   logic        clear_overflow = 1'b0;
   logic [18:0] fb_addr;
   logic [8:0]  fb_data;
   logic        fb_we, overflow, clipped, busy;

   int total = 0;
   int bad = 0;
   int we_count = 0;
   int clip_seen = 0;
   int clip_exp = 0;
   logic [27:0] sb[$];

   vga_pixel_sink #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
      .Clock          (Clock),
      .Resetn         (Resetn),
      .in_x           (in_x),
      .in_y           (in_y),
      .in_color       (in_color),
      .in_write       (in_write),
      .fb_grant       (fb_grant),
      .fb_addr        (fb_addr),
      .fb_data        (fb_data),
      .fb_we          (fb_we),
      .clear_overflow (clear_overflow),
      .overflow       (overflow),
      .clipped        (clipped),
      .busy           (busy)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // monitor: every framebuffer write must match the oldest expected pixel
   initial begin
      logic [27:0] e;
      forever begin
         @(negedge Clock);
         if (fb_we === 1'b1) begin
            we_count++;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got addr %0d data %0d expected no write",
                        fb_addr, fb_data);
            end else begin
               e = sb.pop_front();
               check("fb_addr", int'(fb_addr), int'(e[27:9]));
               check("fb_data", int'(fb_data), int'(e[8:0]));
            end
         end
         if (clipped === 1'b1) clip_seen++;
      end
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic setpix(input int x, input int y, input logic [8:0] c, input bit accept);
      int a;
      in_x     = x[9:0];
      in_y     = y[8:0];
      in_color = c;
      in_write = 1'b1;
      if (x < 640 && y < 480) begin
         a = y * 640 + x;
         if (accept) sb.push_back({a[18:0], c});
      end else begin
         clip_exp++;
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((sb.size() != 0 || busy !== 1'b0) && n < 300) begin
         step();
         n++;
      end
      check({name, "_drain_in_time"}, int'(n < 300), 1);
      check({name, "_busy_low"}, int'(busy), 0);
   endtask

   task automatic do_reset();
      Resetn = 1'b0;
      step();
      sb.delete();
      step();
      Resetn = 1'b1;
   endtask

   initial begin
      int w0;
      int sent;
      bit prev;

      // reset state
      repeat (3) step();
      check("rst_fb_we", int'(fb_we), 0);
      check("rst_fb_addr", int'(fb_addr), 0);
      check("rst_fb_data", int'(fb_data), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_clipped", int'(clipped), 0);
      check("rst_busy", int'(busy), 0);
      Resetn = 1'b1;
      step();

      // T1: single pixel, 4-cycle latency
      fb_grant = 1'b1;
      setpix(10, 2, 9'h038, 1'b1);
      step();
      in_write = 1'b0;
      step();
      step();
      @(negedge Clock);
      check("t1_no_we_at_3", int'(fb_we), 0);
      @(negedge Clock);
      check("t1_we_at_4", int'(fb_we), 1);
      check("t1_addr", int'(fb_addr), 1290);
      #1;
      wait_drain("t1");

      // T2: last on-screen pixel and first off-screen column
      w0 = we_count;
      setpix(639, 479, 9'h1FF, 1'b1);
      step();
      setpix(640, 0, 9'h1C0, 1'b1);
      step();
      in_write = 1'b0;
      wait_drain("t2");
      check("t2_write_count", we_count - w0, 1);
      check("t2_clip_count", clip_seen, clip_exp);

      // T3: 20 writes with no grant; 16 fit, the rest are dropped
      fb_grant = 1'b0;
      for (int i = 0; i < 20; i++) begin
         setpix($urandom_range(0, 639), $urandom_range(0, 479),
                9'($urandom_range(0, 511)), i < 16);
         step();
      end
      in_write = 1'b0;
      repeat (4) step();
      check("t3_overflow", int'(overflow), 1);
      check("t3_busy", int'(busy), 1);
      w0 = we_count;
      fb_grant = 1'b1;
      wait_drain("t3");
      check("t3_write_count", we_count - w0, 16);
      check("t3_overflow_sticky", int'(overflow), 1);

      // clear overflow
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;
      check("clr_overflow", int'(overflow), 0);

      // T4: fill to 16, then push and pop coincide on the full FIFO
      fb_grant = 1'b0;
      w0 = we_count;
      for (int i = 0; i < 16; i++) begin
         setpix($urandom_range(0, 639), $urandom_range(0, 479),
                9'($urandom_range(0, 511)), 1'b1);
         step();
      end
      in_write = 1'b0;
      repeat (3) step();
      setpix(100, 200, 9'h007, 1'b1);
      step();
      in_write = 1'b0;
      step();
      fb_grant = 1'b1;
      step();
      check("t4_no_overflow", int'(overflow), 0);
      wait_drain("t4");
      check("t4_write_count", we_count - w0, 17);
      check("t4_overflow_end", int'(overflow), 0);

      // T5: grant toggling every cycle, 50 spaced writes
      w0 = we_count;
      sent = 0;
      prev = 1'b0;
      for (int c = 0; sent < 50 && c < 2000; c++) begin
         fb_grant = ~fb_grant;
         if (!prev && $urandom_range(0, 1) == 1) begin
            setpix($urandom_range(0, 639), $urandom_range(0, 479),
                   9'($urandom_range(0, 511)), 1'b1);
            sent++;
            prev = 1'b1;
         end else begin
            in_write = 1'b0;
            prev = 1'b0;
         end
         step();
      end
      in_write = 1'b0;
      fb_grant = 1'b1;
      wait_drain("t5");
      check("t5_write_count", we_count - w0, 50);
      check("t5_overflow", int'(overflow), 0);

      // random mix of on- and off-screen pixels with grant held
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) != 0)
            setpix($urandom_range(0, 700), $urandom_range(0, 511),
                   9'($urandom_range(0, 511)), 1'b1);
         else
            in_write = 1'b0;
         step();
      end
      in_write = 1'b0;
      wait_drain("mix");
      check("mix_clip_count", clip_seen, clip_exp);

      // T6: reset with 8 pixels buffered
      fb_grant = 1'b0;
      for (int i = 0; i < 8; i++) begin
         setpix($urandom_range(0, 639), $urandom_range(0, 479),
                9'($urandom_range(0, 511)), 1'b1);
         step();
      end
      in_write = 1'b0;
      repeat (3) step();
      check("t6_busy_before", int'(busy), 1);
      do_reset();
      check("t6_fb_we_after", int'(fb_we), 0);
      check("t6_busy_after", int'(busy), 0);
      check("t6_overflow_after", int'(overflow), 0);
      w0 = we_count;
      fb_grant = 1'b1;
      repeat (20) step();
      check("t6_no_stale_writes", we_count - w0, 0);
      setpix(0, 0, 9'h1C0, 1'b1);
      step();
      in_write = 1'b0;
      wait_drain("t6_post");
      check("t6_post_count", we_count - w0, 1);

      check("final_sb_empty", sb.size(), 0);
      check("final_clip_count", clip_seen, clip_exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
